// File: rtl/mem_arbiter.sv
// Two-port SRAM arbiter: data port A and fetch port B share one async SRAM.
// Define MEM_ARB_RR_EN for round-robin on conflicts (default: A has priority).
module mem_arbiter #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        aReq,
  input  logic        aWrite,
  input  logic [15:0] aAddr,
  input  logic [15:0] aWData,
  output logic [15:0] aRData,
  output logic        aAck,
  input  logic        bReq,
  input  logic [15:0] bAddr,
  output logic [15:0] bRData,
  output logic        bAck,
  output logic [15:0] ramAddr,
  output logic [15:0] ramDataOut,
  input  logic [15:0] ramDataIn,
  output logic        ramDrive,
  output logic        ramCe_n,
  output logic        ramOe_n,
  output logic        ramWe_n,
  output logic        stall
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t     state;
  logic [2:0] cnt;
  logic       isWrite;
  logic       grantB;
  logic       pickB;
  logic       pickWr;

`ifdef MEM_ARB_RR_EN
  logic lastB;
  assign pickB = bReq & (~aReq | ~lastB);
`else
  assign pickB = bReq & ~aReq;
`endif

  assign pickWr = ~pickB & aWrite;
  assign stall  = (aReq & ~aAck) | (bReq & ~bAck);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      isWrite    <= 1'b0;
      grantB     <= 1'b0;
      aAck       <= 1'b0;
      bAck       <= 1'b0;
      aRData     <= '0;
      bRData     <= '0;
      ramAddr    <= '0;
      ramDataOut <= '0;
      ramDrive   <= 1'b0;
      ramCe_n    <= 1'b1;
      ramOe_n    <= 1'b1;
      ramWe_n    <= 1'b1;
`ifdef MEM_ARB_RR_EN
      lastB      <= 1'b1;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (aReq | bReq) begin
            grantB   <= pickB;
            isWrite  <= pickWr;
            ramAddr  <= pickB ? bAddr : aAddr;
            if (pickWr)
              ramDataOut <= aWData;
            cnt      <= 3'(WAIT_CYCLES);
            ramCe_n  <= 1'b0;
            ramOe_n  <= pickWr;
            ramWe_n  <= ~pickWr;
            ramDrive <= pickWr;
`ifdef MEM_ARB_RR_EN
            lastB    <= pickB;
`endif
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
          end else begin
            if (!isWrite) begin
              if (grantB)
                bRData <= ramDataIn;
              else
                aRData <= ramDataIn;
            end
            ramCe_n  <= 1'b1;
            ramOe_n  <= 1'b1;
            ramWe_n  <= 1'b1;
            ramDrive <= 1'b0;
            aAck     <= ~grantB;
            bAck     <= grantB;
            state    <= DONE;
          end
        end
        DONE: begin
          aAck  <= 1'b0;
          bAck  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter with a transaction-level reference model.
// Also honours MEM_ARB_RR_EN so either build can be checked.
module tb_mem_arbiter;

  localparam int W = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        aReq = 1'b0, aWrite = 1'b0;
  logic [15:0] aAddr = '0, aWData = '0;
  logic [15:0] aRData;
  logic        aAck;
  logic        bReq = 1'b0;
  logic [15:0] bAddr = '0;
  logic [15:0] bRData;
  logic        bAck;
  logic [15:0] ramAddr, ramDataOut, ramDataIn;
  logic        ramDrive, ramCe_n, ramOe_n, ramWe_n, stall;

  mem_arbiter #(.WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst),
    .aReq(aReq), .aWrite(aWrite), .aAddr(aAddr), .aWData(aWData),
    .aRData(aRData), .aAck(aAck),
    .bReq(bReq), .bAddr(bAddr), .bRData(bRData), .bAck(bAck),
    .ramAddr(ramAddr), .ramDataOut(ramDataOut), .ramDataIn(ramDataIn),
    .ramDrive(ramDrive), .ramCe_n(ramCe_n), .ramOe_n(ramOe_n),
    .ramWe_n(ramWe_n), .stall(stall)
  );

  always #5 clk = ~clk;

  // SRAM model: unwritten words read back an address-derived pattern
  logic [15:0] mem [256];
  bit          memV [256];

  function automatic logic [15:0] dflt(input logic [15:0] ad);
    return {ad[7:0], ~ad[7:0]} ^ 16'h5A3C;
  endfunction

  assign ramDataIn = memV[ramAddr[7:0]] ? mem[ramAddr[7:0]] : dflt(ramAddr);

  always @(posedge clk)
    if (!ramWe_n && ramDrive && !ramCe_n) begin
      mem[ramAddr[7:0]]  <= ramDataOut;
      memV[ramAddr[7:0]] <= 1'b1;
    end

  int nTests = 0;
  int nFail  = 0;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s @%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  // Reference: one transaction occupies W+3 cycles from grant to next grant
  int          left = 0;
  logic        mB = 1'b0, mW = 1'b0, lastA = 1'b0;
  logic [15:0] mAddr = '0, mData = '0, mRead = '0;
  logic [15:0] expA = '0, expB = '0;
  logic [15:0] sh [256];
  bit          shV [256];
  int          nAckA = 0, nAckB = 0;

  function automatic logic [15:0] shRead(input logic [15:0] ad);
    return shV[ad[7:0]] ? sh[ad[7:0]] : dflt(ad);
  endfunction

  task automatic modelReset();
    left  = 0;
    expA  = '0;
    expB  = '0;
    lastA = 1'b0;
  endtask

  task automatic modelStep();
    logic pB;
    if (left > 0) begin
      left--;
      if (left == 1 && !mW) begin
        if (mB) expB = mRead;
        else    expA = mRead;
      end
    end else if (aReq || bReq) begin
`ifdef MEM_ARB_RR_EN
      pB = bReq && (!aReq || lastA);
`else
      pB = bReq && !aReq;
`endif
      mB    = pB;
      lastA = !pB;
      mW    = !pB && aWrite;
      mAddr = pB ? bAddr : aAddr;
      mData = aWData;
      left  = W + 2;
      if (mW) begin
        sh[mAddr[7:0]]  = mData;
        shV[mAddr[7:0]] = 1'b1;
      end else begin
        mRead = shRead(mAddr);
      end
    end
  endtask

  task automatic checkOutputs();
    logic acc, done, eA, eB;
    acc  = left >= 2;
    done = left == 1;
    eA   = done && !mB;
    eB   = done && mB;
    chk("ce", ramCe_n, !acc);
    chk("oe", ramOe_n, !(acc && !mW));
    chk("we", ramWe_n, !(acc && mW));
    chk("drive", ramDrive, acc && mW);
    if (acc) chk("addr", ramAddr, mAddr);
    if (acc && mW) chk("dout", ramDataOut, mData);
    chk("aAck", aAck, eA);
    chk("bAck", bAck, eB);
    chk("aRData", aRData, expA);
    chk("bRData", bRData, expB);
    chk("stall", stall, (aReq && !eA) || (bReq && !eB));
    if (eA) nAckA++;
    if (eB) nAckB++;
  endtask

  task automatic cycle();
    @(posedge clk);
    modelStep();
    #1 checkOutputs();
    @(negedge clk);
  endtask

  function automatic logic [15:0] rndAddr();
    return 16'($urandom_range(0, 15)) | (16'($urandom_range(0, 255)) << 8);
  endfunction

  task automatic gen();
    logic eA, eB;
    eA = (left == 1) && !mB;
    eB = (left == 1) && mB;
    if (!aReq || eA) begin
      aReq   = ($urandom_range(0, 3) != 0);
      aWrite = 1'($urandom_range(0, 1));
      aAddr  = rndAddr();
      aWData = 16'($urandom);
    end else if ($urandom_range(0, 31) == 0) begin
      aReq = 1'b0;
    end
    if (!bReq || eB) begin
      bReq  = ($urandom_range(0, 3) != 0);
      bAddr = rndAddr();
    end else if ($urandom_range(0, 31) == 0) begin
      bReq = 1'b0;
    end
  endtask

  initial begin
    modelReset();
    #12;
    chk("rstAddr", ramAddr, 16'h0000);
    chk("rstDout", ramDataOut, 16'h0000);
    checkOutputs();
    @(negedge clk);
    rst = 1'b1;

    // write 0x4A21 to 0x0010 so the later fetch has a known word
    aReq = 1'b1; aWrite = 1'b1; aAddr = 16'h0010; aWData = 16'h4A21;
    for (int i = 0; i < W + 3; i++) begin
      cycle();
      if (left == 0) aReq = 1'b0;
    end
    aReq = 1'b0;
    cycle();

    // fetch, then reset during its second ACCESS cycle
    bReq = 1'b1; bAddr = 16'h0010;
    cycle();
    @(posedge clk);
    modelStep();
    #1 checkOutputs();
    #2 rst = 1'b0;
    #1;
    chk("abortCe", ramCe_n, 1'b1);
    chk("abortOe", ramOe_n, 1'b1);
    chk("abortWe", ramWe_n, 1'b1);
    chk("abortAck", bAck, 1'b0);
    modelReset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < W + 3; i++) cycle();
    chk("fetchData", bRData, 16'h4A21);

    // write to high address, data port read-back must be untouched
    bReq = 1'b0;
    aReq = 1'b1; aWrite = 1'b1; aAddr = 16'h8000; aWData = 16'hBEEF;
    for (int i = 0; i < W + 3; i++) begin
      cycle();
      if (left == 0) aReq = 1'b0;
    end
    chk("wrKeepsRData", aRData, 16'h0000);

    for (int i = 0; i < 4000; i++) begin
      cycle();
      gen();
    end
    chk("ackSeenA", 16'(nAckA > 50), 16'h1);
    chk("ackSeenB", 16'(nAckB > 50), 16'h1);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: WAIT_CYCLES, 1, extra SRAM strobe cycles per access (legal 0..7).
REQ-002 Port: clk  in  1  sole clock, rising edge.
REQ-003 Port: rst  in  1  reset, asynchronous, active-low.
REQ-004 Port: aReq  in  1  data-port request; held with aWrite/aAddr/aWData until aAck.
REQ-005 Port: aWrite  in  1  1=write, 0=read.
REQ-006 Port: aAddr  in  16  data address.
REQ-007 Port: aWData  in  16  write data.
REQ-008 Port: aRData  out  16  read data, valid while aAck=1, held until next data read.
REQ-009 Port: aAck  out  1  one-cycle completion pulse, data port.
REQ-010 Port: bReq  in  1  fetch request (read only); held with bAddr until bAck.
REQ-011 Port: bAddr  in  16  fetch address.
REQ-012 Port: bRData  out  16  fetched word, valid while bAck=1, held until next fetch.
REQ-013 Port: bAck  out  1  one-cycle completion pulse, fetch port.
REQ-014 Port: ramAddr  out  16  SRAM address.
REQ-015 Port: ramDataOut  out  16  SRAM write data.
REQ-016 Port: ramDataIn  in  16  SRAM read data.
REQ-017 Port: ramDrive  out  1  1=enable external tristate driver for ramDataOut.
REQ-018 Port: ramCe_n, ramOe_n, ramWe_n  out  1 each  active-low SRAM strobes.
REQ-019 Port: stall  out  1  pipeline freeze: (aReq & ~aAck) | (bReq & ~bAck), combinational.

Function
REQ-020 FSM states IDLE, ACCESS, DONE; all outputs except stall registered.
REQ-021 IDLE: no request -> stay; else grant one port, latch its address/data/direction and grantee, load counter = WAIT_CYCLES, go ACCESS.
REQ-022 Arbitration (default): aReq beats bReq when both high in the same IDLE cycle.
REQ-023 ACCESS: ramCe_n=0, ramAddr=latched address for the whole state; read: ramOe_n=0, ramWe_n=1, ramDrive=0; write: ramOe_n=1, ramWe_n=0, ramDrive=1, ramDataOut=latched data.
REQ-024 ACCESS: counter>0 -> decrement, stay; counter=0 -> capture ramDataIn into grantee's RData on reads, go DONE.
REQ-025 DONE: strobes inactive (all 1), ramDrive=0, grantee's Ack=1 for exactly this cycle; go IDLE unconditionally.
REQ-026 Latency: req high at edge N (FSM in IDLE) -> Ack high in cycle N+WAIT_CYCLES+2; one access per WAIT_CYCLES+3 cycles.
REQ-027 aAck and bAck never high in the same cycle; writes do not modify aRData.
REQ-028 Request dropped during ACCESS: access completes, Ack still pulsed; requester ignores it.
REQ-029 Inputs changing during ACCESS have no effect (latched values used).
REQ-030 Request held high through DONE: treated as a new request in the following IDLE cycle.

Reset
REQ-031 rst=0 forces, asynchronously: state=IDLE, counter=0, aAck=bAck=0, aRData=bRData=0, ramAddr=0, ramDataOut=0, ramDrive=0, ramCe_n=ramOe_n=ramWe_n=1, last-grantee=B.
REQ-032 Reset mid-ACCESS aborts the access with no Ack; first grant is possible on the first rising edge after rst returns to 1.

Configuration
REQ-033 Macro MEM_ARB_RR_EN defined: on simultaneous aReq/bReq in IDLE, grant the port not granted last (last-grantee register updated at each grant); single requests granted immediately.
REQ-034 Macro MEM_ARB_RR_EN undefined: fixed priority per REQ-022; no last-grantee register.

Verification (WAIT_CYCLES=1)
REQ-035 Fetch: bReq=1, bAddr=0x0010, ramDataIn=0x4A21 -> ramOe_n=0 for 2 cycles at ramAddr 0x0010; bAck pulses 3 cycles after request edge; bRData=0x4A21.
REQ-036 Write: aReq=1, aWrite=1, aAddr=0x8000, aWData=0xBEEF -> ramWe_n=0, ramDrive=1, ramDataOut=0xBEEF for 2 cycles; aAck one pulse; aRData unchanged.
REQ-037 Conflict: aReq and bReq high in same IDLE cycle -> default: A served then B (aAck before bAck, 3 cycles apart plus 1 IDLE); with MEM_ARB_RR_EN after a prior A grant: B first.
REQ-038 stall: bReq held from request to bAck -> stall=1 every cycle except the bAck cycle; stall=0 with no requests.
REQ-039 Reset: assert rst=0 in 2nd ACCESS cycle of a read -> strobes all 1 immediately, no Ack; after release, held bReq served normally.
REQ-040 Starvation check (RR build): aReq and bReq held continuously 20 cycles -> Acks alternate A,B,A,B.
